simple_st0_seq: RTL and testbench
=================================

Name: simple_st0_seq

Overview:
- Pass sequencer for one neural stage.
- Accepts a burst of input data words, then walks the tap memory read port for the forward pass and presents one result handshake.
- Optionally waits for an error word, then walks the tap memory write port for the tap update.
- Sits between the stage input/error streams and the stage's data FIFO, error FIFO and output control, driving their timing and tap addresses.

Parameters:
- TAP_AW, 4, tap memory address width (max 2^TAP_AW taps).
- LEN_W, 3, width of load length field.

Ports:
- clk  in  1  clock.
- reset  in  1  reset.
- cfg_load_length  in  LEN_W  data beats per pass minus 1.
- cfg_tap_length  in  TAP_AW  taps per pass minus 1.
- cfg_error_mode  in  1  1 = run error/update phase after each pass.
- cfg_continuous  in  1  1 = return to LOAD after a pass instead of IDLE.
- start  in  1  single-cycle start request.
- data_vld  in  1  input data valid.
- data_rdy  out  1  input data ready.
- error_vld  in  1  error word valid.
- error_rdy  out  1  error word ready.
- tap_rd_en  out  1  tap memory read strobe.
- tap_rd_addr  out  TAP_AW  tap read address.
- tap_wr_en  out  1  tap memory write strobe.
- tap_wr_addr  out  TAP_AW  tap write address.
- out_vld  out  1  stage result valid.
- out_fst  out  1  first result since start.
- out_rdy  in  1  downstream ready for result.
- busy  out  1  not in IDLE.
- done  out  1  one-cycle pulse on return to IDLE.

Behaviour:
- Interface: one clock; reset is synchronous and active-low. `reset` is sampled only on the rising edge of `clk`; reset == 0 clears all state on that edge.
- Reset values:
  - State = IDLE; all counters = 0; first flag = 1.
  - All outputs 0: data_rdy, error_rdy, tap_rd_en, tap_wr_en, out_vld, out_fst, busy, done, and both address outputs.
- Config latching: cfg_* are captured into shadow registers on start accepted in IDLE. They are also recaptured on each LOAD entry from UPD or OUT when cfg_continuous = 1. Config changes mid-pass have no effect.
- States: IDLE, LOAD, FWD, OUT, ERR, UPD.
- IDLE:
  - start = 1 -> LOAD next cycle, first flag set.
  - start is ignored in every other state.
- LOAD:
  - data_rdy = 1 (registered, asserted the cycle after entry).
  - Beat counter increments on data_vld & data_rdy.
  - On the beat where count == cfg_load_length: go to FWD. data_rdy drops in the same cycle the transition registers.
  - data_vld while data_rdy = 0 is ignored (not counted).
- FWD:
  - tap_rd_en = 1 every cycle; tap_rd_addr = 0, 1, … cfg_tap_length, one per cycle, no stalls.
  - After issuing addr cfg_tap_length -> OUT.
  - FWD lasts exactly cfg_tap_length+1 cycles.
- OUT:
  - out_vld = 1, held until out_rdy; out_fst = first flag, held with out_vld.
  - On out_vld & out_rdy: clear first flag. Then go to ERR if cfg_error_mode; else to LOAD if cfg_continuous; else to IDLE with done = 1 for one cycle.
  - out_rdy low stalls indefinitely; no timeout.
- ERR:
  - error_rdy = 1; wait for error_vld.
  - On handshake -> UPD.
  - error_vld outside ERR is not acknowledged.
- UPD:
  - tap_wr_en = 1; tap_wr_addr = 0 … cfg_tap_length, one per cycle.
  - After the last address: go to LOAD if cfg_continuous; else to IDLE with done pulse.
- Mutual exclusion: tap_rd_en and tap_wr_en are never both 1.
- Address defaults: address outputs are 0 when their strobe is 0.
- busy: 1 in every state except IDLE; done and busy both change on the IDLE transition edge.
- Wrap: tap address counter saturates at cfg_tap_length and never wraps. cfg_tap_length = 2^TAP_AW-1 gives full-range addressing with no overflow.
- Boundaries:
  - cfg_load_length = 0: exactly one data beat.
  - cfg_tap_length = 0: a single read (FWD) or write (UPD) cycle.
- Reset mid-operation: immediate return to IDLE on the next edge. No done pulse; strobes drop that edge.
- Outputs: all are registered.

Test Plan:
- Basic pass: reset, start with load_length=3, tap_length=5, error_mode=0, continuous=0, data_vld constant -> 4 accepted beats; tap_rd_en 6 cycles with addr 0..5; out_vld with out_fst=1; done pulse 1 cycle after out_rdy; busy returns to 0.
- Backpressure: out_rdy held low 10 cycles in OUT -> out_vld/out_fst held stable 10 cycles, no state advance, no tap strobes.
- Error mode: error_mode=1, tap_length=2, error_vld delayed 7 cycles -> error_rdy high 7+1 cycles; then tap_wr_en 3 cycles addr 0,1,2; tap_rd_en stays 0 throughout.
- Continuous: continuous=1, two passes -> second pass out_fst=0; LOAD re-entered without done; config changed mid-pass applies only from second LOAD.
- Corners: load_length=0 and tap_length=0 -> one data beat, one read cycle; tap_length=15 -> addr reaches 15 without wrap; gapped data_vld (1010…) -> exactly load_length+1 counted beats.
- Reset/ignore: reset=0 during FWD at addr 3 -> next edge all outputs 0, state IDLE, no done. start pulsed in LOAD -> ignored. error_vld in LOAD -> error_rdy stays 0.

Source files
------------

// File: rtl/simple_st0_seq.sv
// Pass sequencer for one neural stage: load a data burst, walk tap reads,
// hand off one result, then optionally take an error word and walk tap writes.
module simple_st0_seq #(
  parameter int TAP_AW = 4,
  parameter int LEN_W  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [LEN_W-1:0]  cfg_load_length,
  input  logic [TAP_AW-1:0] cfg_tap_length,
  input  logic              cfg_error_mode,
  input  logic              cfg_continuous,
  input  logic              start,
  input  logic              data_vld,
  output logic              data_rdy,
  input  logic              error_vld,
  output logic              error_rdy,
  output logic              tap_rd_en,
  output logic [TAP_AW-1:0] tap_rd_addr,
  output logic              tap_wr_en,
  output logic [TAP_AW-1:0] tap_wr_addr,
  output logic              out_vld,
  output logic              out_fst,
  input  logic              out_rdy,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FWD, S_OUT, S_ERR, S_UPD} state_t;

  typedef struct packed {
    logic [LEN_W-1:0]  load_len;
    logic [TAP_AW-1:0] tap_len;
    logic              err_mode;
    logic              cont;
  } cfg_t;

  state_t            state_q, state_d;
  cfg_t              cfg_q;
  logic              ld_cfg;
  logic [LEN_W-1:0]  beat_q, beat_d;
  logic [TAP_AW-1:0] tap_q, tap_d;
  logic              first_q, first_d;

  logic              data_rdy_d, error_rdy_d, tap_rd_en_d, tap_wr_en_d;
  logic [TAP_AW-1:0] tap_rd_addr_d, tap_wr_addr_d;
  logic              out_vld_d, out_fst_d, busy_d, done_d;

  // State, counters, shadow config and every output are registered here.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cfg_q       <= '0;
      beat_q      <= '0;
      tap_q       <= '0;
      first_q     <= 1'b1;
      data_rdy    <= 1'b0;
      error_rdy   <= 1'b0;
      tap_rd_en   <= 1'b0;
      tap_rd_addr <= '0;
      tap_wr_en   <= 1'b0;
      tap_wr_addr <= '0;
      out_vld     <= 1'b0;
      out_fst     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      tap_q       <= tap_d;
      first_q     <= first_d;
      if (ld_cfg)
        cfg_q <= '{load_len: cfg_load_length, tap_len: cfg_tap_length,
                   err_mode: cfg_error_mode, cont: cfg_continuous};
      data_rdy    <= data_rdy_d;
      error_rdy   <= error_rdy_d;
      tap_rd_en   <= tap_rd_en_d;
      tap_rd_addr <= tap_rd_addr_d;
      tap_wr_en   <= tap_wr_en_d;
      tap_wr_addr <= tap_wr_addr_d;
      out_vld     <= out_vld_d;
      out_fst     <= out_fst_d;
      busy        <= busy_d;
      done        <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    tap_d   = tap_q;
    first_d = first_q;
    ld_cfg  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_LOAD;
        first_d = 1'b1;
        beat_d  = '0;
        ld_cfg  = 1'b1;
      end
      S_LOAD: if (data_vld && data_rdy) begin
        if (beat_q == cfg_q.load_len) begin
          state_d = S_FWD;
          tap_d   = '0;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      S_FWD: begin
        if (tap_q == cfg_q.tap_len) state_d = S_OUT;
        else                        tap_d   = tap_q + 1'b1;
      end
      S_OUT: if (out_rdy) begin
        first_d = 1'b0;
        if (cfg_q.err_mode) begin
          state_d = S_ERR;
        end else if (cfg_q.cont) begin
          state_d = S_LOAD;
          beat_d  = '0;
          ld_cfg  = 1'b1;
        end else begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      S_ERR: if (error_vld) begin
        state_d = S_UPD;
        tap_d   = '0;
      end
      S_UPD: begin
        if (tap_q != cfg_q.tap_len) begin
          tap_d = tap_q + 1'b1;
        end else if (cfg_q.cont) begin
          state_d = S_LOAD;
          beat_d  = '0;
          ld_cfg  = 1'b1;
        end else begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode the next state so they line up with the state register.
  always_comb begin
    data_rdy_d    = (state_d == S_LOAD);
    error_rdy_d   = (state_d == S_ERR);
    tap_rd_en_d   = (state_d == S_FWD);
    tap_wr_en_d   = (state_d == S_UPD);
    tap_rd_addr_d = tap_rd_en_d ? tap_d : '0;
    tap_wr_addr_d = tap_wr_en_d ? tap_d : '0;
    out_vld_d     = (state_d == S_OUT);
    out_fst_d     = out_vld_d && first_d;
    busy_d        = (state_d != S_IDLE);
  end

endmodule

// File: tb/tb_simple_st0_seq.sv
// Scoreboard bench for simple_st0_seq: expected tap addresses and out_fst
// values are queued per pass and consumed as the DUT produces them.
module tb_simple_st0_seq;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] cfg_load_length = '0;
  logic [3:0] cfg_tap_length = '0;
  logic       cfg_error_mode = 1'b0, cfg_continuous = 1'b0;
  logic       start = 1'b0, data_vld = 1'b0, error_vld = 1'b0, out_rdy = 1'b1;
  logic       data_rdy, error_rdy, tap_rd_en, tap_wr_en, out_vld, out_fst, busy, done;
  logic [3:0] tap_rd_addr, tap_wr_addr;

  simple_st0_seq #(.TAP_AW(4), .LEN_W(3)) dut (
    .clk(clk), .reset(reset),
    .cfg_load_length(cfg_load_length), .cfg_tap_length(cfg_tap_length),
    .cfg_error_mode(cfg_error_mode), .cfg_continuous(cfg_continuous),
    .start(start), .data_vld(data_vld), .data_rdy(data_rdy),
    .error_vld(error_vld), .error_rdy(error_rdy),
    .tap_rd_en(tap_rd_en), .tap_rd_addr(tap_rd_addr),
    .tap_wr_en(tap_wr_en), .tap_wr_addr(tap_wr_addr),
    .out_vld(out_vld), .out_fst(out_fst), .out_rdy(out_rdy),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0, ncyc = 0;
  int n_beats = 0, n_errs = 0, n_done = 0, n_erdy = 0, last_ohs = 0, done_cyc = 0;
  int rd_q[$], wr_q[$], out_q[$];
  logic prev_drdy = 1'b0, prev_erdy = 1'b0, prev_ovld = 1'b0, prev_ofst = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, ncyc);
    end
  endtask

  // Handshakes use the ready/valid sampled last cycle with the inputs held since then.
  task automatic monitor();
    int e;
    if (prev_drdy && data_vld) n_beats++;
    if (prev_erdy && error_vld) n_errs++;
    if (prev_ovld && out_rdy) begin
      last_ohs = ncyc;
      if (out_q.size() > 0) e = out_q.pop_front(); else e = 9;
      chk("out_fst", prev_ofst, e);
    end
    chk("mutex", tap_rd_en & tap_wr_en, 0);
    chk("state_excl", error_rdy & data_rdy, 0);
    if (tap_rd_en) begin
      if (rd_q.size() > 0) e = rd_q.pop_front(); else e = 999;
      chk("rd_addr", tap_rd_addr, e);
    end else chk("rd_addr_off", tap_rd_addr, 0);
    if (tap_wr_en) begin
      if (wr_q.size() > 0) e = wr_q.pop_front(); else e = 999;
      chk("wr_addr", tap_wr_addr, e);
    end else chk("wr_addr_off", tap_wr_addr, 0);
    if (!out_vld) chk("fst_off", out_fst, 0);
    if (error_rdy) n_erdy++;
    if (done) n_done++;
    prev_drdy = data_rdy; prev_erdy = error_rdy;
    prev_ovld = out_vld;  prev_ofst = out_fst;
  endtask

  task automatic cyc();
    @(negedge clk);
    ncyc++;
    monitor();
  endtask

  task automatic clr();
    n_beats = 0; n_errs = 0; n_done = 0; n_erdy = 0;
  endtask

  task automatic go();
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("busy_start", busy, 1);
    chk("rdy_start", data_rdy, 1);
  endtask

  task automatic run_until_done(input int max, input bit gap);
    bit seen = 0;
    for (int i = 0; i < max && !seen; i++) begin
      cyc();
      if (done) begin
        seen = 1;
        done_cyc = ncyc;
        chk("busy_at_done", busy, 0);
      end else if (gap) data_vld = ~data_vld;
    end
    chk("done_seen", seen, 1);
    cyc();
    chk("done_pulse", done, 0);
  endtask

  task automatic end_test(input string name, input int beats, input int dones, input int errs);
    chk({name, "_beats"}, n_beats, beats);
    chk({name, "_dones"}, n_done, dones);
    chk({name, "_errs"}, n_errs, errs);
    chk({name, "_rd_left"}, rd_q.size(), 0);
    chk({name, "_wr_left"}, wr_q.size(), 0);
    chk({name, "_out_left"}, out_q.size(), 0);
    chk({name, "_busy"}, busy, 0);
    clr();
  endtask

  function automatic logic [15:0] outs();
    return {data_rdy, error_rdy, tap_rd_en, tap_wr_en, out_vld, out_fst, busy, done,
            tap_rd_addr, tap_wr_addr};
  endfunction

  initial begin
    bit seen;
    repeat (3) cyc();
    chk("reset_outs", outs(), 0);
    reset = 1'b1;
    cyc();
    chk("idle_outs", outs(), 0);
    clr();

    // Basic pass
    cfg_load_length = 3; cfg_tap_length = 5; data_vld = 1'b1; out_rdy = 1'b1;
    for (int i = 0; i <= 5; i++) rd_q.push_back(i);
    out_q.push_back(1);
    go();
    run_until_done(60, 0);
    chk("done_lat", done_cyc, last_ohs);
    end_test("basic", 4, 1, 0);

    // Backpressure on the result handshake
    cfg_load_length = 0; cfg_tap_length = 1; out_rdy = 1'b0;
    rd_q.push_back(0); rd_q.push_back(1); out_q.push_back(1);
    go();
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin cyc(); if (out_vld) seen = 1; end
    chk("bp_reach_out", seen, 1);
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("bp_vld", out_vld, 1);
      chk("bp_fst", out_fst, 1);
      chk("bp_strobes", tap_rd_en | tap_wr_en, 0);
    end
    out_rdy = 1'b1;
    run_until_done(10, 0);
    end_test("bp", 1, 1, 0);

    // Error mode with a delayed error word
    cfg_load_length = 1; cfg_tap_length = 2; cfg_error_mode = 1'b1;
    for (int i = 0; i <= 2; i++) begin rd_q.push_back(i); wr_q.push_back(i); end
    out_q.push_back(1);
    go();
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin cyc(); if (error_rdy) seen = 1; end
    chk("err_reach", seen, 1);
    repeat (7) cyc();
    error_vld = 1'b1;
    cyc();
    error_vld = 1'b0;
    chk("err_rdy_drop", error_rdy, 0);
    run_until_done(20, 0);
    chk("err_rdy_cycles", n_erdy, 8);
    end_test("err", 2, 1, 1);
    cfg_error_mode = 1'b0;

    // Continuous: mid-pass config changes apply from the second LOAD
    cfg_load_length = 1; cfg_tap_length = 1; cfg_continuous = 1'b1;
    rd_q.push_back(0); rd_q.push_back(1); out_q.push_back(1);
    for (int i = 0; i <= 3; i++) rd_q.push_back(i);
    out_q.push_back(0);
    go();
    cfg_load_length = 0; cfg_tap_length = 3; cfg_continuous = 1'b0;
    run_until_done(60, 0);
    end_test("cont", 3, 1, 0);

    // Minimum lengths
    cfg_load_length = 0; cfg_tap_length = 0;
    rd_q.push_back(0); out_q.push_back(1);
    go();
    run_until_done(20, 0);
    end_test("min", 1, 1, 0);

    // Full tap range, gapped data, stray start and error_vld in LOAD
    cfg_load_length = 4; cfg_tap_length = 15; error_vld = 1'b1;
    for (int i = 0; i <= 15; i++) rd_q.push_back(i);
    out_q.push_back(1);
    go();
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("load_erdy", error_rdy, 0);
    run_until_done(80, 1);
    error_vld = 1'b0; data_vld = 1'b1;
    end_test("gap", 5, 1, 0);

    // Reset in the middle of FWD
    cfg_load_length = 0; cfg_tap_length = 7;
    for (int i = 0; i <= 7; i++) rd_q.push_back(i);
    go();
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      cyc();
      if (tap_rd_en && tap_rd_addr == 4'd3) seen = 1;
    end
    chk("rst_reach_addr3", seen, 1);
    reset = 1'b0;
    cyc();
    chk("rst_mid_outs", outs(), 0);
    reset = 1'b1;
    rd_q.delete();
    cyc();
    chk("rst_no_done", n_done, 0);
    cfg_tap_length = 0;
    rd_q.push_back(0); out_q.push_back(1);
    go();
    run_until_done(20, 0);
    end_test("rst", 2, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
